tdm_demux: RTL and testbench
============================

# tdm_demux

Serial time-division demultiplexer: receives a framed, bit-serial stream carrying `NCH` channels of `W` bits each and delivers each slot as a registered parallel word on its own channel output with a one-cycle strobe. It is the receiving end of the team's N:1 TDM multiplexer path and sits between the serial link and per-channel consumers.

## Interface
- `NCH`, 4, number of channel slots per frame (≥2)
- `W`, 8, bits per slot (≥2)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `sdata`  in  1  serial data bit, MSB of each slot first
- `sdata_en`  in  1  `sdata` (and `fsync`) sampled only when high
- `fsync`  in  1  frame sync; qualified by `sdata_en`; marks bit 0 of slot 0
- `ch_data`  out  `NCH*W`  channel words; channel k at bits `[k*W +: W]`
- `ch_valid`  out  `NCH`  bit k pulses one cycle when channel k updates
- `frame_done`  out  1  one-cycle pulse after the last slot (or parity bit) of a frame
- `frame_err`  out  1  one-cycle pulse when a frame is aborted by an early `fsync`
- `parity_err`  out  1  one-cycle pulse on parity mismatch (see Configuration)

## Operation
- States: `IDLE` (hunting for fsync), `RUN` (receiving slots), `PAR` (parity bit, only with macro).
- `IDLE`: enabled bits without `fsync` are ignored. Enabled bit with `fsync=1` → load as bit 0 of slot 0, go `RUN`.
- `RUN`: each enabled bit shifts into the slot shift register; bit counter 0..W-1, slot counter 0..NCH-1.
- When bit W-1 of slot k is sampled: `ch_data[k]` ← assembled word, `ch_valid[k]` pulses; other channels hold.
- After slot NCH-1 completes: no macro → `frame_done` pulses, go `IDLE`; macro → go `PAR`.
- Early `fsync` in `RUN` (any enabled bit other than frame bit 0): `frame_err` pulses, partial slot discarded, already-delivered slots of the aborted frame remain, counters restart with this bit as bit 0 of slot 0, stay `RUN`.
- `fsync` on the first enabled bit after a completed frame is the normal back-to-back case, no error.
- `sdata_en=0`: all state holds, no pulses.
- All outputs are registers; all pulses single-cycle.

## Timing
- Reset values: `ch_data`=0, `ch_valid`=0, `frame_done`=0, `frame_err`=0, `parity_err`=0, state `IDLE`, counters 0.
- Latency: word and `ch_valid[k]` appear after the same `clk` edge that samples the slot's final bit (zero extra cycles).
- `frame_done` coincides with `ch_valid[NCH-1]` (no macro) or with the parity-bit edge (macro).
- `frame_err` is asserted after the edge that samples the offending `fsync`.
- Reset mid-frame: everything returns to reset values immediately; next frame needs a fresh `fsync`.
- Counter widths: `$clog2(W)` and `$clog2(NCH)`, minimum 1 bit.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined: each frame is followed by one enabled bit carrying even parity over all `NCH*W` data bits. State `PAR` samples it; mismatch → `parity_err` pulses with `frame_done`. `fsync` in `PAR` → `frame_err`, treated as new frame start. Channel words are delivered regardless of parity outcome.
- Not defined: no `PAR` state, no parity bit in the frame, `parity_err` tied 0.

## Structure
- Package `tdm_pkg`: state enum (`IDLE`, `RUN`, `PAR`), default `NCH`/`W` constants, slot-index helper for `ch_data` slicing; shared with the TDM multiplexer.
- Sub-module `tdm_shift_in`: W-bit MSB-first shift register with enable and synchronous clear; top holds FSM, counters, output registers.

## Test plan
- Reset then frame fsync + slots 0xA5,0x3C,0xFF,0x01 with `sdata_en`=1 continuous → `ch_valid` pulses 0001,0010,0100,1000 at bit-edges 8,16,24,32; `ch_data`=0x01FF3CA5; `frame_done` with last.
- Same frame with `sdata_en` toggling every other cycle → identical words, pulses spaced 16 cycles.
- Enabled bits with no `fsync` for 40 cycles → no pulses, `ch_data` stays 0.
- `fsync` at bit 3 of slot 2 → `frame_err` pulse, slots 0–1 retained, new frame 0x11,0x22,0x33,0x44 decodes correctly.
- Two back-to-back frames (second `fsync` on bit 33) → two `frame_done`, no `frame_err`.
- Macro on: correct parity → `parity_err`=0; flipped parity bit → `parity_err` pulse with `frame_done`; `rst_n` low mid-slot → all outputs 0 asynchronously.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM definitions: FSM states, default frame geometry, slot slicing helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdm_pkg;

    localparam int TDM_NCH = 4;
    localparam int TDM_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAR  = 2'd2
    } tdm_state_t;

    // LSB position of slot k inside a flattened NCH*W channel bus.
    function automatic int slot_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/tdm_shift_in.sv
// MSB-first serial-to-parallel shifter; word presents the W-bit value including the current din.
// Latency: word is combinational on din, so the final bit of a slot is usable on its own sampling edge.
// Backpressure: none; shifts only when en is high, clr empties the history.
module tdm_shift_in
    import tdm_pkg::*;
#(
    parameter int W = TDM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         din,
    output logic [W-1:0] word
);

    // Only W-1 bits need storing: the W-th bit is the one being sampled.
    logic [W-2:0] hist;

    assign word = {hist, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (clr) begin
            hist <= '0;
        end else if (en) begin
            hist <= word[W-2:0];
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Framed bit-serial TDM demultiplexer; optional trailing even-parity bit with TDM_DEMUX_PARITY_EN.
// Latency: word and ch_valid[k] registered on the edge sampling the slot's last bit.
// Backpressure: none; sdata_en qualifies every input bit, state holds while it is low.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NCH = TDM_NCH,
    parameter int W   = TDM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sdata,
    input  logic             sdata_en,
    input  logic             fsync,
    output logic [NCH*W-1:0] ch_data,
    output logic [NCH-1:0]   ch_valid,
    output logic             frame_done,
    output logic             frame_err,
    output logic             parity_err
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    tdm_state_t      state, state_nxt;
    logic [BW-1:0]   bit_cnt, bit_nxt;
    logic [SW-1:0]   slot_cnt, slot_nxt;
    logic            load_slot, done_nxt, err_nxt, sh_clr;
    logic [W-1:0]    word;

`ifdef TDM_DEMUX_PARITY_EN
    logic            par_acc, par_nxt, perr_nxt;
`endif

    tdm_shift_in #(.W(W)) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sdata_en),
        .clr   (sh_clr),
        .din   (sdata),
        .word  (word)
    );

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        slot_nxt  = slot_cnt;
        load_slot = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        sh_clr    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_nxt   = par_acc;
        perr_nxt  = 1'b0;
`endif
        if (sdata_en) begin
            case (state)
                IDLE: begin
                    if (fsync) begin
                        state_nxt = RUN;
                        bit_nxt   = BW'(1);
                        slot_nxt  = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        par_nxt   = sdata;
`endif
                    end else begin
                        sh_clr = 1'b1;
                    end
                end
                RUN: begin
                    // Frame bit 0 is always consumed in IDLE/PAR, so any fsync seen here is early.
                    if (fsync) begin
                        err_nxt  = 1'b1;
                        bit_nxt  = BW'(1);
                        slot_nxt = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        par_nxt  = sdata;
`endif
                    end else begin
`ifdef TDM_DEMUX_PARITY_EN
                        par_nxt = par_acc ^ sdata;
`endif
                        if (bit_cnt == BW'(W - 1)) begin
                            load_slot = 1'b1;
                            bit_nxt   = '0;
                            if (slot_cnt == SW'(NCH - 1)) begin
                                slot_nxt = '0;
`ifdef TDM_DEMUX_PARITY_EN
                                state_nxt = PAR;
`else
                                done_nxt  = 1'b1;
                                state_nxt = IDLE;
`endif
                            end else begin
                                slot_nxt = slot_cnt + SW'(1);
                            end
                        end else begin
                            bit_nxt = bit_cnt + BW'(1);
                        end
                    end
                end
`ifdef TDM_DEMUX_PARITY_EN
                PAR: begin
                    if (fsync) begin
                        err_nxt   = 1'b1;
                        state_nxt = RUN;
                        bit_nxt   = BW'(1);
                        slot_nxt  = '0;
                        par_nxt   = sdata;
                    end else begin
                        done_nxt  = 1'b1;
                        perr_nxt  = par_acc ^ sdata;
                        state_nxt = IDLE;
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            slot_cnt   <= '0;
            ch_data    <= '0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_nxt;
            slot_cnt   <= slot_nxt;
            ch_valid   <= '0;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            for (int k = 0; k < NCH; k++) begin
                if (load_slot && slot_cnt == SW'(k)) begin
                    ch_data[slot_lsb(k, W) +: W] <= word;
                    ch_valid[k]                  <= 1'b1;
                end
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_acc    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_acc    <= par_nxt;
            parity_err <= perr_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: stimulus pushes expected output events, a negedge monitor pops and compares.
module tb_tdm_demux;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             sdata    = 1'b0;
    logic             sdata_en = 1'b0;
    logic             fsync    = 1'b0;
    logic [NCH*W-1:0] ch_data;
    logic [NCH-1:0]   ch_valid;
    logic             frame_done;
    logic             frame_err;
    logic             parity_err;

    tdm_demux #(.NCH(NCH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sdata      (sdata),
        .sdata_en   (sdata_en),
        .fsync      (fsync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [NCH-1:0]   vld;
        logic [NCH*W-1:0] dat;
        logic             done;
        logic             err;
        logic             perr;
    } ev_t;

    ev_t              exp_q[$];
    int               checks   = 0;
    int               errors   = 0;
    int               cyc      = 0;
    logic [NCH*W-1:0] exp_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected event for the edge about to sample the bit being driven.
    task automatic push(input logic [NCH-1:0] v, input logic d, input logic er, input logic pe);
        ev_t e;
        e.cyc  = cyc + 1;
        e.vld  = v;
        e.dat  = exp_data;
        e.done = d;
        e.err  = er;
        e.perr = pe;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (|ch_valid || frame_done || frame_err || parity_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: cycle %0d vld %b done %b err %b perr %b, none expected",
                         cyc, ch_valid, frame_done, frame_err, parity_err);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", 64'(cyc), 64'(e.cyc));
                check("ch_valid", 64'(ch_valid), 64'(e.vld));
                check("ch_data", 64'(ch_data), 64'(e.dat));
                check("frame_done", 64'(frame_done), 64'(e.done));
                check("frame_err", 64'(frame_err), 64'(e.err));
                check("parity_err", 64'(parity_err), 64'(e.perr));
            end
        end
    end

    task automatic send_bit(input logic b, input logic fs, input int gap);
        sdata    = b;
        fsync    = fs;
        sdata_en = 1'b1;
        @(posedge clk);
        #1;
        sdata_en = 1'b0;
        fsync    = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_slot(input int s, input logic [W-1:0] w, input int nbits,
                             input logic fs, input logic err, input int gap);
        for (int i = 0; i < nbits; i++) begin
            logic           f;
            logic [NCH-1:0] v;
            f = fs && (i == 0);
            if (f && err) push('0, 1'b0, 1'b1, 1'b0);
            if (i == W - 1) begin
                exp_data[s*W +: W] = w;
                v    = '0;
                v[s] = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                push(v, 1'b0, 1'b0, 1'b0);
`else
                push(v, (s == NCH - 1), 1'b0, 1'b0);
`endif
            end
            send_bit(w[W-1-i], f, gap);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic [W-1:0] w2, input logic [W-1:0] w3,
                              input int gap, input logic err_first, input logic flip_par);
        logic [W-1:0] w[NCH];
        w = '{w0, w1, w2, w3};
        for (int s = 0; s < NCH; s++)
            send_slot(s, w[s], W, (s == 0), err_first && (s == 0), gap);
`ifdef TDM_DEMUX_PARITY_EN
        push('0, 1'b1, 1'b0, flip_par);
        send_bit((^{w0, w1, w2, w3}) ^ flip_par, 1'b0, gap);
`else
        if (flip_par) $display("note: no parity bit in this build, flip ignored");
`endif
    endtask

    initial begin
        logic [39:0] noise;
        noise = 40'hF0A5_3C96_E1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ch_data", 64'(ch_data), 64'd0);
        check("reset_ch_valid", 64'(ch_valid), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        check("reset_parity_err", 64'(parity_err), 64'd0);
        rst_n = 1'b1;

        // Enabled bits without fsync must be ignored.
        for (int i = 0; i < 40; i++) send_bit(noise[i], 1'b0, 0);
        check("idle_ch_data", 64'(ch_data), 64'd0);

        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, 1'b0, 1'b0);
        check("frame1_ch_data", 64'(ch_data), 64'h01FF3CA5);

        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1, 1'b0, 1'b0);
        check("gapped_ch_data", 64'(ch_data), 64'h01FF3CA5);

        // Abort at bit 3 of slot 2; that fsync bit starts the next frame.
        send_slot(0, 8'h5A, W, 1'b1, 1'b0, 0);
        send_slot(1, 8'hC3, W, 1'b0, 1'b0, 0);
        check("abort_partial_ch_data", 64'(ch_data), 64'h01FFC35A);
        send_slot(2, 8'h77, 3, 1'b0, 1'b0, 0);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0, 1'b1, 1'b0);
        check("after_abort_ch_data", 64'(ch_data), 64'h44332211);

        send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, 1'b0, 1'b0);
        send_frame(8'h12, 8'h34, 8'h56, 8'h78, 0, 1'b0, 1'b0);
        check("b2b_ch_data", 64'(ch_data), 64'h78563412);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(8'h81, 8'h7E, 8'h03, 8'hC0, 0, 1'b0, 1'b0);
        send_frame(8'h81, 8'h7E, 8'h03, 8'hC0, 0, 1'b0, 1'b1);
        check("parity_ch_data", 64'(ch_data), 64'hC0037E81);
`endif

        // Asynchronous reset mid-slot.
        send_slot(0, 8'hAA, 3, 1'b1, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("arst_ch_data", 64'(ch_data), 64'd0);
        check("arst_ch_valid", 64'(ch_valid), 64'd0);
        check("arst_frame_done", 64'(frame_done), 64'd0);
        check("arst_frame_err", 64'(frame_err), 64'd0);
        check("arst_parity_err", 64'(parity_err), 64'd0);
        exp_data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Leftover slot bits after reset carry no fsync and must be ignored.
        for (int i = 0; i < W; i++) send_bit(1'b1, 1'b0, 0);
        check("post_reset_idle_ch_data", 64'(ch_data), 64'd0);
        send_frame(8'hCA, 8'hFE, 8'hBA, 8'hBE, 0, 1'b0, 1'b0);
        check("post_reset_frame_ch_data", 64'(ch_data), 64'hBEBAFECA);

        repeat (4) @(posedge clk);
        #1;
        check("pending_events", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
